joy_serial_reader: RTL and testbench

Reads the two DB9 joysticks through the board's serial shift-register chain and presents debounced, active-low 8-bit joystick words to the arcade core. It sits between the `JOY_CLK`/`JOY_LOAD`/`JOY_DATA` pins and the top-level wiring that feeds `I_JOYSTICK_A/B`, `I_PLAYER` and `I_COIN`. It replaces the inline divider/sampler in the top level, and adds an input synchronizer, per-bit debounce and a frame-complete strobe.

---
 rtl/joy_pkg.sv | 16 +
 rtl/joy_debounce_bit.sv | 33 +++
 rtl/joy_serial_reader.sv | 73 +++++++
 tb/tb_joy_serial_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared constants for the DB9 joystick reader: bit positions within an
// active-low joystick word and the idle (nothing pressed) value.
package joy_pkg;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE1 = 4;
    localparam int JOY_FIRE2 = 5;
    localparam int JOY_FIRE3 = 6;
    localparam int JOY_START = 7;

    localparam logic [7:0] JOY_IDLE = 8'hFF;

endpackage

// File: rtl/joy_debounce_bit.sv
// One debounced joystick bit: the output only follows the raw frame value
// after it has disagreed for DEBOUNCE_FRAMES consecutive frame commits.
module joy_debounce_bit #(
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic commit,
    input  logic raw,
    output logic out
);

    localparam logic [2:0] LAST = 3'(DEBOUNCE_FRAMES - 1);

    logic [2:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            out <= 1'b1;
        end else if (commit) begin
            if (raw == out) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                out <= raw;
                cnt <= '0;
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/joy_serial_reader.sv
// Serial reader for two DB9 joysticks on a parallel-load shift chain:
// input synchronizer, shift clock divider, 16-state sequencer and debouncers.
module joy_serial_reader
    import joy_pkg::*;
#(
    parameter int CLKDIV_W        = 8,
    parameter int DEBOUNCE_FRAMES = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       JOY_DATA,
    output logic       JOY_CLK,
    output logic       JOY_LOAD,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic       frame_strobe
);

    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 7) begin : g_bad_frames
        $fatal(1, "joy_serial_reader: DEBOUNCE_FRAMES must be in 1..7");
    end

    logic                data_sync_p0;
    logic                data_sync_p1;
    logic [CLKDIV_W-1:0] div;
    logic [3:0]          state;
    logic [15:0]         raw;
    logic                commit;
    logic                tick;
    logic [15:0]         out;

    assign tick = (div == '0);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
            div          <= '0;
            state        <= '0;
            raw          <= {JOY_IDLE, JOY_IDLE};
            commit       <= 1'b0;
        end else begin
            data_sync_p0 <= JOY_DATA;
            data_sync_p1 <= data_sync_p0;
            div          <= div + CLKDIV_W'(1);
            // The state-15 tick completes the word; debouncers see it next cycle.
            commit       <= tick && (state == 4'd15);
            if (tick) begin
                raw[~state] <= data_sync_p1;
                state       <= state + 4'd1;
            end
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_bit
        joy_debounce_bit #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
        ) u_debounce (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .commit (commit),
            .raw    (raw[i]),
            .out    (out[i])
        );
    end

    assign JOY_CLK      = div[CLKDIV_W-1];
    assign JOY_LOAD     = (state != 4'd0);
    assign frame_strobe = commit;
    assign joystick1    = out[15:8];
    assign joystick2    = out[7:0];

endmodule

// File: tb/tb_joy_serial_reader.sv
// Directed bench for joy_serial_reader: two instances (1-frame and 2-frame
// debounce) read a behavioural parallel-load shift chain driven by the bench.
module tb_joy_serial_reader;
    import joy_pkg::*;

    localparam logic [15:0] J1_FIRE1 = 16'h0001 << (8 + JOY_FIRE1);
    localparam logic [15:0] ALL_UP   = {JOY_IDLE, JOY_IDLE};

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        joy_data;
    logic        clk_a, load_a, strobe_a;
    logic        clk_b, load_b, strobe_b;
    logic [7:0]  j1a, j2a, j1b, j2b;
    logic [15:0] chain_word = 16'hFFFF;
    logic [15:0] sr = 16'hFFFF;
    logic        clk_d = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk_sys = ~clk_sys;

    joy_serial_reader #(.CLKDIV_W(4), .DEBOUNCE_FRAMES(1)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .JOY_DATA(joy_data),
        .JOY_CLK(clk_a), .JOY_LOAD(load_a), .joystick1(j1a),
        .joystick2(j2a), .frame_strobe(strobe_a)
    );

    joy_serial_reader #(.CLKDIV_W(4), .DEBOUNCE_FRAMES(2)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .JOY_DATA(joy_data),
        .JOY_CLK(clk_b), .JOY_LOAD(load_b), .joystick1(j1b),
        .joystick2(j2b), .frame_strobe(strobe_b)
    );

    // Shift chain: loads while LOAD is low, shifts on each JOY_CLK rise.
    always @(posedge clk_sys) begin
        if (!load_a)
            sr <= chain_word;
        else if (clk_a && !clk_d)
            sr <= {sr[14:0], 1'b1};
        clk_d <= clk_a;
    end
    assign joy_data = sr[15];

    task automatic wait_strobe(input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk_sys); #1;
            cycles++;
            if (strobe_a) return;
        end
        checks++;
        errors++;
        $display("FAIL strobe_timeout: got no frame_strobe within %0d cycles", budget);
    endtask

    task automatic next_frame(input logic [15:0] w);
        int n;
        chain_word = w;
        wait_strobe(400, n);
        @(posedge clk_sys); #1;
    endtask

    task automatic test_reset;
        chain_word = ALL_UP;
        reset_n = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        checks++; if (j1a !== 8'hFF) begin errors++; $display("FAIL reset_j1a: got %h expected ff", j1a); end
        checks++; if (j2a !== 8'hFF) begin errors++; $display("FAIL reset_j2a: got %h expected ff", j2a); end
        checks++; if (j1b !== 8'hFF) begin errors++; $display("FAIL reset_j1b: got %h expected ff", j1b); end
        checks++; if (j2b !== 8'hFF) begin errors++; $display("FAIL reset_j2b: got %h expected ff", j2b); end
        checks++; if (load_a !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load_a); end
        checks++; if (clk_a !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", clk_a); end
        checks++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", strobe_a); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        #1;
        checks++; if (load_a !== 1'b0) begin errors++; $display("FAIL load_state0: got %b expected 0", load_a); end
        @(posedge clk_sys); #1;
        checks++; if (load_a !== 1'b1) begin errors++; $display("FAIL load_state1: got %b expected 1", load_a); end
        repeat (7) @(posedge clk_sys);
        #1;
        checks++; if (clk_a !== 1'b1) begin errors++; $display("FAIL joy_clk_rise: got %b expected 1", clk_a); end
    endtask

    task automatic test_first_commit;
        int n;
        wait_strobe(400, n);
        checks++; if (n !== 233) begin errors++; $display("FAIL first_commit_cycle: got %0d expected 233", n); end
        checks++; if (j1a !== 8'hFF) begin errors++; $display("FAIL strobe_cycle_j1a: got %h expected ff", j1a); end
        @(posedge clk_sys); #1;
        checks++; if (strobe_a !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", strobe_a); end
        checks++; if (j2a !== 8'hFF) begin errors++; $display("FAIL first_frame_j2a: got %h expected ff", j2a); end
    endtask

    task automatic test_bit_mapping;
        next_frame(16'b0111_1111_1111_1110);
        checks++; if (j1a !== 8'h7F) begin errors++; $display("FAIL map_j1a: got %h expected 7f", j1a); end
        checks++; if (j2a !== 8'hFE) begin errors++; $display("FAIL map_j2a: got %h expected fe", j2a); end
        checks++; if (j1b !== 8'hFF) begin errors++; $display("FAIL map_j1b: got %h expected ff", j1b); end
        checks++; if (j2b !== 8'hFF) begin errors++; $display("FAIL map_j2b: got %h expected ff", j2b); end
        next_frame(ALL_UP);
        checks++; if (j1a !== 8'hFF) begin errors++; $display("FAIL map_release_j1a: got %h expected ff", j1a); end
        checks++; if (j2b !== 8'hFF) begin errors++; $display("FAIL map_release_j2b: got %h expected ff", j2b); end
    endtask

    task automatic test_debounce;
        next_frame(ALL_UP & ~J1_FIRE1);
        checks++; if (j1a !== 8'hEF) begin errors++; $display("FAIL glitch_j1a: got %h expected ef", j1a); end
        checks++; if (j1b !== 8'hFF) begin errors++; $display("FAIL glitch_j1b: got %h expected ff", j1b); end
        next_frame(ALL_UP);
        checks++; if (j1b !== 8'hFF) begin errors++; $display("FAIL glitch_end_j1b: got %h expected ff", j1b); end
        next_frame(ALL_UP & ~J1_FIRE1);
        checks++; if (j1b !== 8'hFF) begin errors++; $display("FAIL hold1_j1b: got %h expected ff", j1b); end
        next_frame(ALL_UP & ~J1_FIRE1);
        checks++; if (j1b !== 8'hEF) begin errors++; $display("FAIL hold2_j1b: got %h expected ef", j1b); end
        checks++; if (j2b !== 8'hFF) begin errors++; $display("FAIL hold2_j2b: got %h expected ff", j2b); end
    endtask

    task automatic test_release_bounce;
        logic [15:0] words [5];
        logic [7:0]  exp_b [5];
        words = '{ALL_UP & ~J1_FIRE1, ALL_UP, ALL_UP & ~J1_FIRE1, ALL_UP, ALL_UP};
        exp_b = '{8'hEF, 8'hEF, 8'hEF, 8'hEF, 8'hFF};
        for (int k = 0; k < 5; k++) begin
            next_frame(words[k]);
            checks++;
            if (j1b !== exp_b[k]) begin
                errors++;
                $display("FAIL bounce_j1b[%0d]: got %h expected %h", k, j1b, exp_b[k]);
            end
            checks++;
            if (j1a !== words[k][15:8]) begin
                errors++;
                $display("FAIL bounce_j1a[%0d]: got %h expected %h", k, j1a, words[k][15:8]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        next_frame(16'h0000);
        next_frame(16'h0000);
        checks++; if (j1b !== 8'h00) begin errors++; $display("FAIL pressed_j1b: got %h expected 00", j1b); end
        checks++; if (j2b !== 8'h00) begin errors++; $display("FAIL pressed_j2b: got %h expected 00", j2b); end
        // One cycle past the strobe; state 9 spans strobe+144 .. strobe+159.
        repeat (148) @(posedge clk_sys);
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (j1a !== 8'hFF) begin errors++; $display("FAIL mid_reset_j1a: got %h expected ff", j1a); end
        checks++; if (j2b !== 8'hFF) begin errors++; $display("FAIL mid_reset_j2b: got %h expected ff", j2b); end
        checks++; if (load_a !== 1'b0) begin errors++; $display("FAIL mid_reset_load: got %b expected 0", load_a); end
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_strobe(400, n);
        checks++; if (n !== 241) begin errors++; $display("FAIL restart_commit_cycle: got %0d expected 241", n); end
        @(posedge clk_sys); #1;
        checks++; if (j2a !== 8'h00) begin errors++; $display("FAIL restart_j2a: got %h expected 00", j2a); end
        checks++; if (j1a[6:0] !== 7'h00) begin errors++; $display("FAIL restart_j1a_low: got %h expected 00", j1a[6:0]); end
        checks++; if (j1b !== 8'hFF) begin errors++; $display("FAIL restart_j1b: got %h expected ff", j1b); end
    endtask

    task automatic test_frame_period;
        int n, hi, pos, lowc;
        chain_word = ALL_UP;
        wait_strobe(400, n);
        for (int f = 0; f < 3; f++) begin
            hi = 0; pos = 0; lowc = 0;
            for (int c = 1; c <= 256; c++) begin
                @(posedge clk_sys); #1;
                if (strobe_a) begin hi++; pos = c; end
                if (!load_a) lowc++;
            end
            checks++; if (hi !== 1) begin errors++; $display("FAIL period_width[%0d]: got %0d high cycles expected 1", f, hi); end
            checks++; if (pos !== 256) begin errors++; $display("FAIL period_gap[%0d]: got %0d expected 256", f, pos); end
            checks++; if (lowc !== 16) begin errors++; $display("FAIL load_low[%0d]: got %0d expected 16", f, lowc); end
        end
    endtask

    initial begin
        test_reset;
        test_first_commit;
        test_bit_mapping;
        test_debounce;
        test_release_bounce;
        test_reset_mid_frame;
        test_frame_period;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
